// File: rtl/vram_write_queue.sv
// CPU-to-VRAM write queue: buffers {addr, data} writes and drains them to gpu_m only while vblank is high.
// Optional sticky drop flag enabled by defining VRAM_WQ_OVERFLOW_FLAG_EN.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 13
`endif

module vram_write_queue #(
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_12_5875,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  vblank,
    output logic [7:0]            vram_data,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic                  vram_cs,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = ADDR_WIDTH + 8;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [ENTRY_W-1:0]      head;
    logic                    push, pop;

    // Handshake: a write transfers on a rising edge where wr_valid && wr_ready; wr_ready
    // depends on the held count only, so a full queue refuses even when a pop is under way.
    assign wr_ready = (count_q != FULL_CNT);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == STROBE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vblank && count_q != '0) state_d = SETUP;
            SETUP:   state_d = vblank ? STROBE : IDLE;
            // The strobe itself always completes; vblank only decides whether another follows.
            STROBE:  state_d = (vblank && count_d != '0) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_12_5875) begin
        if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
    end

    // The head slot cannot be overwritten while occupied, so it is stable over SETUP+STROBE.
    assign head         = mem_q[rd_ptr_q];
    assign vram_address = (state_q != IDLE) ? head[ENTRY_W-1:8] : '0;
    assign vram_data    = (state_q != IDLE) ? head[7:0] : '0;
    assign vram_cs      = (state_q == STROBE);
    assign fifo_count   = count_q;
    assign dbg_state    = state_q;

`ifdef VRAM_WQ_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: reset, hold-off, ordered drain, full/drop, vblank edges,
// steady streaming with pointer wrap, and reset during a strobe.
module tb_vram_write_queue;

    localparam int AW = 13;
    localparam int DL = 4;
    localparam int EW = AW + 8;

`ifdef VRAM_WQ_OVERFLOW_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk_12_5875 = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          vblank;
    logic [7:0]    vram_data;
    logic [AW-1:0] vram_address;
    logic          vram_cs;
    logic [DL:0]   fifo_count;
    logic          overflow;
    logic [1:0]    dbg_state;

    int checks     = 0;
    int errors     = 0;
    int strobe_cnt = 0;
    int s0;
    logic [EW-1:0] exp_q[$];

    vram_write_queue #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
        .clk_12_5875  (clk_12_5875),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .vblank       (vblank),
        .vram_data    (vram_data),
        .vram_address (vram_address),
        .vram_cs      (vram_cs),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // clock / watchdog
    always #5 clk_12_5875 = ~clk_12_5875;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_12_5875);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        if (wr_ready) exp_q.push_back({a, d});
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_empty(input int max_cyc);
        int n;
        n = 0;
        while ((fifo_count != 0 || dbg_state != 2'd0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_done", {31'd0, (fifo_count == 0 && dbg_state == 2'd0)}, 32'd1);
    endtask

    // scoreboard: every strobe must match the oldest accepted write
    always @(negedge clk_12_5875) begin
        if (vram_cs === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("strobe_addr", 32'(vram_address), 32'(e[EW-1:8]));
                chk("strobe_data", 32'(vram_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        vblank   = 1'b0;
        #2;
        chk("rst_cs", 32'(vram_cs), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(vram_address), 32'd0);
        chk("rst_data", 32'(vram_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // hold-off while vblank is low
        s0 = strobe_cnt;
        push(13'h010, 8'hAA);
        push(13'h011, 8'hBB);
        push(13'h012, 8'hCC);
        repeat (3) tick();
        chk("hold_count", 32'(fifo_count), 32'd3);
        chk("hold_no_strobe", 32'(strobe_cnt - s0), 32'd0);

        // ordered drain: strobes two, four and six cycles after vblank rises
        vblank = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("drain_cs_%0d", k), 32'(vram_cs), 32'((k == 2 || k == 4 || k == 6) ? 1 : 0));
            if (k == 1) chk("setup_addr", 32'(vram_address), 32'h010);
        end
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_state", 32'(dbg_state), 32'd0);
        chk("drain_strobes", 32'(strobe_cnt - s0), 32'd3);

        // fill to full, 17th write dropped
        vblank = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("fill_ready_%0d", i), 32'(wr_ready), 32'((i < 16) ? 1 : 0));
            push(AW'(13'h040 + i), 8'(8'h30 + i));
        end
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_ovf", 32'(overflow), 32'(OVF_EXP));
        vblank = 1'b1;
        wait_empty(100);
        chk("full_q_empty", 32'(exp_q.size()), 32'd0);

        // vblank falls during SETUP, then during STROBE
        vblank = 1'b0;
        push(13'h080, 8'h11);
        push(13'h081, 8'h22);
        s0 = strobe_cnt;
        vblank = 1'b1;
        tick();
        chk("vb_setup_state", 32'(dbg_state), 32'd1);
        vblank = 1'b0;
        tick();
        chk("vb_setup_cs", 32'(vram_cs), 32'd0);
        tick();
        chk("vb_setup_count", 32'(fifo_count), 32'd2);
        chk("vb_setup_strobes", 32'(strobe_cnt - s0), 32'd0);
        vblank = 1'b1;
        tick();
        tick();
        chk("vb_strobe_cs", 32'(vram_cs), 32'd1);
        vblank = 1'b0;
        repeat (3) tick();
        chk("vb_strobe_count", 32'(fifo_count), 32'd1);
        chk("vb_strobe_strobes", 32'(strobe_cnt - s0), 32'd1);
        vblank = 1'b1;
        wait_empty(20);

        // steady streaming, one push per two cycles, pointers wrap
        s0 = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            push(AW'(13'h100 + i), 8'(i * 7 + 1));
            if (i >= 1) chk($sformatf("steady_count_%0d", i), 32'(fifo_count), 32'd2);
            tick();
        end
        wait_empty(20);
        chk("steady_strobes", 32'(strobe_cnt - s0), 32'd20);
        chk("steady_q_empty", 32'(exp_q.size()), 32'd0);

        // reset during STROBE with five queued
        vblank = 1'b0;
        for (int i = 0; i < 5; i++) push(AW'(13'h200 + i), 8'(8'hE0 + i));
        chk("rs_count", 32'(fifo_count), 32'd5);
        vblank = 1'b1;
        tick();
        tick();
        chk("rs_in_strobe", 32'(vram_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_cs", 32'(vram_cs), 32'd0);
        chk("rs_count0", 32'(fifo_count), 32'd0);
        chk("rs_ready", 32'(wr_ready), 32'd1);
        chk("rs_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        s0 = strobe_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rs_quiet_cs_%0d", k), 32'(vram_cs), 32'd0);
        end
        chk("rs_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        push(13'h2AB, 8'h5A);
        wait_empty(20);
        chk("rs_new_strobe", 32'(strobe_cnt - s0), 32'd1);
        chk("rs_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
